// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv - JESD204 TPL ADC capture sequencer (arm, sync, reset pulse, SOF align, gated capture)
// Optional wait-limit feature: AD_IP_JESD204_TPL_ADC_CAPTURE_TIMEOUT_EN
module ad_ip_jesd204_tpl_adc_capture_ctrl #(
  parameter int OCTETS_PER_BEAT   = 4,
  parameter int CAPTURE_LEN_WIDTH = 16,
  parameter int TIMEOUT_WIDTH     = 24,
  parameter int RST_PULSE_LEN     = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         sync_in,
  input  logic                         link_valid,
  input  logic [OCTETS_PER_BEAT-1:0]   link_sof,
  input  logic [CAPTURE_LEN_WIDTH-1:0] capture_len,
  input  logic [TIMEOUT_WIDTH-1:0]     timeout_cycles,
  output logic                         adc_rst_sync,
  output logic                         capture_en,
  output logic                         sync_status,
  output logic                         done,
  output logic                         timeout,
  output logic [CAPTURE_LEN_WIDTH-1:0] beat_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_RST, S_ALIGN, S_CAPTURE, S_DONE
  } state_t;

  localparam logic [3:0] RST_LAST = 4'(RST_PULSE_LEN - 1);
  localparam logic [CAPTURE_LEN_WIDTH-1:0] LEN_ONE = CAPTURE_LEN_WIDTH'(1);

  state_t                       state;
  logic                         sync_d;
  logic [CAPTURE_LEN_WIDTH-1:0] len_q;
  logic [3:0]                   rst_cnt;
  logic                         rise;
  logic                         sof_beat;
  logic                         last_beat;
  logic                         arm_accept;
  logic                         to_hit;

  assign rise       = sync_in & ~sync_d;
  assign sof_beat   = link_valid & link_sof[0];
  // len_q == 0 means continuous, so the terminal compare must never fire then
  assign last_beat  = (len_q != '0) && link_valid && (beat_count == len_q - LEN_ONE);
  assign arm_accept = arm && !abort && ((state == S_IDLE) || (state == S_DONE));

`ifdef AD_IP_JESD204_TPL_ADC_CAPTURE_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] to_cnt;
  logic                     waiting;
  logic                     unused_inputs;

  assign unused_inputs = ^link_sof;
  assign waiting = (state == S_ARMED) || (state == S_RST) || (state == S_ALIGN);
  assign to_hit  = waiting && (timeout_cycles != '0) &&
                   (to_cnt == timeout_cycles - TIMEOUT_WIDTH'(1));

  // Counter idles at zero outside the wait states, so entry to ARMED starts it clean
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      to_cnt <= waiting ? to_cnt + TIMEOUT_WIDTH'(1) : '0;
      if (arm_accept)
        timeout <= 1'b0;
      else if (!abort && to_hit)
        timeout <= 1'b1;
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{link_sof, timeout_cycles};
  assign to_hit        = 1'b0;
  assign timeout       = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      sync_d       <= 1'b0;
      len_q        <= '0;
      rst_cnt      <= '0;
      adc_rst_sync <= 1'b0;
      capture_en   <= 1'b0;
      sync_status  <= 1'b0;
      done         <= 1'b0;
      beat_count   <= '0;
    end else begin
      sync_d <= sync_in;
      if (abort) begin
        state        <= S_IDLE;
        adc_rst_sync <= 1'b0;
        capture_en   <= 1'b0;
        sync_status  <= 1'b0;
        done         <= 1'b0;
      end else if (to_hit) begin
        state        <= S_IDLE;
        adc_rst_sync <= 1'b0;
        sync_status  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (arm) begin
              state       <= S_ARMED;
              len_q       <= capture_len;
              done        <= 1'b0;
              beat_count  <= '0;
              sync_status <= 1'b1;
            end
          end
          S_ARMED: begin
            if (rise) begin
              state        <= S_RST;
              adc_rst_sync <= 1'b1;
              rst_cnt      <= '0;
            end
          end
          S_RST: begin
            if (rst_cnt == RST_LAST) begin
              state        <= S_ALIGN;
              adc_rst_sync <= 1'b0;
            end else begin
              rst_cnt <= rst_cnt + 4'd1;
            end
          end
          S_ALIGN: begin
            if (sof_beat) begin
              sync_status <= 1'b0;
              beat_count  <= LEN_ONE;
              // A one-beat capture is complete on the SOF beat itself
              if (len_q == LEN_ONE) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state      <= S_CAPTURE;
                capture_en <= 1'b1;
              end
            end
          end
          S_CAPTURE: begin
            if (link_valid) begin
              beat_count <= beat_count + LEN_ONE;
              if (last_beat) begin
                state      <= S_DONE;
                capture_en <= 1'b0;
                done       <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ad_ip_jesd204_tpl_adc_capture_ctrl.md
Name: ad_ip_jesd204_tpl_adc_capture_ctrl

Overview:
- Link-clock-domain sequencer for the JESD204 transport-layer ADC datapath.
- Arms on a software request, waits for an external sync edge, then pulses the datapath reset.
- Aligns the start of capture to the next start-of-frame beat and gates sample-valid for a programmed number of beats, or continuously.
- Sits between the register map (arm/abort/length) and the TPL core/DMA valid path.

Parameters:
OCTETS_PER_BEAT, 4, width of link_sof; one bit per octet of a beat
CAPTURE_LEN_WIDTH, 16, width of capture_len and beat_count
TIMEOUT_WIDTH, 24, width of timeout_cycles (used only with the optional feature)
RST_PULSE_LEN, 4, cycles adc_rst_sync is held high; range 1..15

Ports:
clk  input  1  link clock; all logic is synchronous to it
resetn  input  1  asynchronous active-low reset
arm  input  1  single-cycle request to arm a capture
abort  input  1  single-cycle request to return to IDLE
sync_in  input  1  external trigger, already synchronised to clk; only its rising edge is used
link_valid  input  1  link beat valid
link_sof  input  OCTETS_PER_BEAT  start-of-frame per octet; only bit 0 is used for alignment
capture_len  input  CAPTURE_LEN_WIDTH  beats to capture; 0 = continuous
timeout_cycles  input  TIMEOUT_WIDTH  wait limit for ARMED+ALIGN; 0 = none
adc_rst_sync  output  1  datapath reset pulse
capture_en  output  1  gates adc_valid downstream
sync_status  output  1  high while waiting for sync or alignment
done  output  1  sticky; set when a finite capture completes
timeout  output  1  sticky; set when the wait limit expires
beat_count  output  CAPTURE_LEN_WIDTH  beats captured so far

Behaviour:
- Reset: state IDLE; all outputs 0; sync_in edge register 0; internal length and timeout counters 0.
- Edge detect: sync_d <= sync_in every cycle in every state. rise = sync_in & ~sync_d. A level already high at arm does not trigger.
- States: IDLE, ARMED, RST, ALIGN, CAPTURE, DONE. All outputs are registered, so every state change becomes visible one cycle after the causing input.
- IDLE:
  - arm -> ARMED.
  - On the arm cycle: latch capture_len, clear done, timeout and beat_count.
- ARMED:
  - sync_status = 1.
  - rise -> RST.
- RST:
  - adc_rst_sync = 1 for exactly RST_PULSE_LEN cycles, then -> ALIGN.
  - sync_status stays 1.
- ALIGN:
  - sync_status = 1.
  - link_valid & link_sof[0] -> CAPTURE.
  - capture_en rises the cycle after the SOF beat. This matches the core's one-stage output pipeline, so the SOF beat is the first beat gated through.
- CAPTURE:
  - capture_en = 1.
  - beat_count += 1 on each link_valid cycle, counting the SOF beat as beat 1.
  - Finite length: when link_valid and beat_count == len-1 -> DONE. On the next cycle capture_en = 0, done = 1, beat_count = len.
  - len = 0: remains in CAPTURE; beat_count wraps to 0 after all-ones.
  - Beats with link_valid = 0 are not counted and do not advance state.
- DONE:
  - done held at 1.
  - arm -> ARMED, performing the same latch/clear as from IDLE.
- Arm while in ARMED, RST, ALIGN or CAPTURE: ignored. It does not restart and does not relatch the length.
- abort in any state: IDLE next cycle; capture_en, adc_rst_sync, sync_status and done go to 0; beat_count is held. abort wins over a simultaneous arm.
- abort during RST truncates the reset pulse immediately.
- capture_len = 1: DONE after the SOF beat alone.
- rise and SOF in the same cycle while ARMED: only the RST transition is taken; the SOF is ignored.
- resetn asserted mid-capture: all outputs 0 asynchronously; IDLE on release.

Optional Feature:
- Macro: AD_IP_JESD204_TPL_ADC_CAPTURE_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_WIDTH counter is cleared on entry to ARMED and increments each cycle in ARMED, RST and ALIGN.
  - If timeout_cycles != 0 and the counter reaches timeout_cycles-1, the block goes to IDLE next cycle with timeout = 1 (sticky until the next arm) and sync_status = 0.
  - timeout_cycles = 0 disables the limit.
- Not defined: no counter is built; the timeout output is tied 0; the timeout_cycles port is present but ignored.

Test Plan:
- Length-4 capture: capture_len=4, arm, sync_in rises 10 cycles later -> adc_rst_sync high for 4 cycles; capture_en rises the cycle after the next link_valid&sof[0] beat; falls after 4 valid beats; done=1; beat_count=4.
- Pre-high sync: sync_in already 1 before arm -> no trigger until sync_in drops to 0 and rises again.
- Valid gaps and continuous mode: link_valid toggled 1010… during a length-6 capture -> beat_count reaches 6 after 11 cycles. With capture_len=0 and CAPTURE_LEN_WIDTH=4 -> beat_count wraps 15->0 and capture_en stays 1.
- Abort and arm priority: abort during RST (second pulse cycle) -> adc_rst_sync 0 next cycle, state IDLE. arm+abort in the same cycle from IDLE -> remains IDLE.
- Re-arm: second arm while in CAPTURE -> ignored (length unchanged). arm from DONE -> done clears next cycle, sync_status=1.
- Timeout (macro on): timeout_cycles=100, no sync_in -> IDLE with timeout=1 after 100 cycles in ARMED. Macro off -> timeout stays 0 indefinitely.
